wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Parametrised Wishbone classic-cycle arbiter that shares one slave port among `MASTERS` masters. It supports any master count, selectable round-robin or fixed-priority grant, a bus-error path, and a watchdog that aborts stalled cycles. It sits between the master-side cores (CPU, DMA, debug) and the shared memory/peripheral interconnect. All logic runs on the rising edge of one clock.

## Interface
Parameters:
- `MASTERS`, 2 — number of masters; any value ≥ 2 (not restricted to powers of two).
- `ADDRESS_WIDTH`, 32 — address bus width.
- `DATA_WIDTH`, 32 — data bus width.
- `SEL_WIDTH`, `DATA_WIDTH/8` — byte-select width.
- `MODE`, 0 — 0 = round-robin; 1 = fixed priority, lowest index wins.
- `TIMEOUT`, 256 — cycles of strobe without ack/err before abort; 0 disables the watchdog.

Ports:
- `clk` in 1 — clock; rising edge only.
- `rst` in 1 — reset, synchronous, active-high.
- `mCycI`, `mStbI`, `mWeI` in `MASTERS` each — per-master cycle, strobe, write enable.
- `mAdrIPacked` in `ADDRESS_WIDTH*MASTERS` — master i occupies slice [i*AW +: AW].
- `mDatIPacked` in `DATA_WIDTH*MASTERS` — master write data, same packing.
- `mSelIPacked` in `SEL_WIDTH*MASTERS` — byte selects, same packing.
- `mAckO`, `mErrO` out `MASTERS` each — per-master ack and error.
- `mDatOPacked` out `DATA_WIDTH*MASTERS` — `sDatI` broadcast to every slice.
- `sCycO`, `sStbO`, `sWeO` out 1 each — slave cycle, strobe, write enable.
- `sAdrO` out `ADDRESS_WIDTH` — slave address.
- `sDatO` out `DATA_WIDTH` — slave write data.
- `sSelO` out `SEL_WIDTH` — slave byte selects.
- `sAckI`, `sErrI` in 1 each — slave ack and error.
- `sDatI` in `DATA_WIDTH` — slave read data.
- `grant` out `$clog2(MASTERS)` — index of the current owner.
- `grantValid` out 1 — high in the BUSY state.
- `timeoutO` out 1 — one-cycle pulse when the watchdog fires.

## Operation
State machine with three states: IDLE, BUSY, ABORT.

- **IDLE**
  - If any `mCycI` bit is set, register the winner into `grant` and move to BUSY.
  - Round-robin: search starts at `last+1` and wraps from `MASTERS-1` to 0. `last` is the previous owner; it resets to `MASTERS-1`, so master 0 has first priority after reset.
  - Fixed priority: the lowest set index wins.
- **BUSY**
  - Slave outputs mirror the owner combinationally: `sCycO=mCycI[g]`, `sStbO=mStbI[g]`, `sWeO=mWeI[g]`; address, data and select are muxed from the owner.
  - `mAckO[g]=sAckI`, `mErrO[g]=sErrI`; all other masters see 0.
  - A request from another master never preempts the owner.
  - When `mCycI[g]` falls: `last<=g` and move to IDLE.
- **ABORT**
  - `sCycO`/`sStbO`/`sWeO` are 0; `mErrO[g]` is held high while `mCycI[g]` remains set.
  - When `mCycI[g]` falls: `last<=g` and move to IDLE.
- **Watchdog**
  - Counter `$clog2(TIMEOUT+1)` bits wide.
  - Clears on any cycle without `mStbI[g]`, on `sAckI`, on `sErrI`, and outside BUSY.
  - Otherwise increments by one per cycle, saturating.
  - When it reaches `TIMEOUT` in BUSY: pulse `timeoutO` and move to ABORT.
  - With `TIMEOUT=0` the counter is removed and ABORT is unreachable.
- **Error path:** `sErrI` and `sAckI` asserted together: forward both; the master resolves.

## Timing
- **Reset values:** state IDLE, `grant=0`, `grantValid=0`, `last=MASTERS-1`, counter 0. All slave control outputs, `mAckO`, `mErrO` and `timeoutO` are 0.
- **Grant latency:** a request seen in IDLE at edge N gives BUSY and slave signals valid after edge N, i.e. one cycle of arbitration latency.
- **Release:** one IDLE cycle between consecutive grants. This is the only bubble.
- **Combinational paths:** ack/err/read data back to the master are combinational within BUSY, with zero added latency.
- **Simultaneous events:** watchdog expiry in the same cycle as `sAckI`: the ack wins and the counter clears.
- **Reset mid-cycle:** immediately drops `sCycO`; no ack or err is reported to the interrupted master.
- **Wrap-around:** `last=MASTERS-1` searches from index 0. Arithmetic is modulo `MASTERS`, not modulo a power of two.

## Structure
- Package `wb_arb_pkg`: state enum (IDLE/BUSY/ABORT), `MODE_RR`/`MODE_FIXED` constants.
- Sub-module `wb_rr_pick`: combinational `req[MASTERS]` plus `last` in, `winner` and `any` out, implementing both modes. Unit-tested on its own.

## Test plan
- **Fairness:** `MASTERS=3`, RR, all three hold `mCycI` continuously with one-beat cycles → grants in order 0,1,2,0,1,2, one idle cycle between each.
- **Fixed priority:** `MODE=1`, masters 1 and 2 both requesting → master 1 is served repeatedly; master 2 is granted only once master 1 drops `mCycI`.
- **No preemption:** master 0 owns a 5-beat burst, master 1 requests at beat 2 → master 1 is granted 1 cycle after master 0 releases; `mAckO[1]` stays 0 throughout.
- **Watchdog:** `TIMEOUT=4`, slave never acks → `timeoutO` pulses on the 4th stalled cycle, `sCycO` drops, `mErrO[g]` stays high until the master drops `mCycI`, then the next master is granted.
- **Reset mid-cycle:** `rst` during BUSY → next cycle `sCycO=0`, `grantValid=0`, `last=MASTERS-1`, and master 0 wins the first arbitration after reset.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone classic-cycle arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arbState_t;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational winner selection: round-robin starting after 'last', or lowest-index fixed priority.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int MASTERS = 2,
    parameter int MODE    = MODE_RR,
    localparam int GW     = $clog2(MASTERS)
)(
    input  logic [MASTERS-1:0] req,
    input  logic [GW-1:0]      last,
    output logic [GW-1:0]      winner,
    output logic               any
);

    logic [GW-1:0] rrWinner;
    logic [GW-1:0] fixWinner;
    int            idx;

    always_comb begin
        rrWinner  = '0;
        fixWinner = '0;
        idx       = 0;
        // Both walks run backwards so the last hit written is the closest one.
        for (int k = MASTERS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= MASTERS) idx = idx - MASTERS;
            if (req[idx]) rrWinner = GW'(idx);
        end
        for (int i = MASTERS - 1; i >= 0; i--) begin
            if (req[i]) fixWinner = GW'(i);
        end
    end

    assign winner = (MODE == MODE_FIXED) ? fixWinner : rrWinner;
    assign any    = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone classic-cycle arbiter: MASTERS masters share one slave port, with
// round-robin or fixed priority, pass-through bus errors and a stall watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MASTERS       = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SEL_WIDTH     = DATA_WIDTH / 8,
    parameter int MODE          = MODE_RR,
    parameter int TIMEOUT       = 256,
    localparam int GW           = $clog2(MASTERS)
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MASTERS-1:0]                mCycI,
    input  logic [MASTERS-1:0]                mStbI,
    input  logic [MASTERS-1:0]                mWeI,
    input  logic [ADDRESS_WIDTH*MASTERS-1:0]  mAdrIPacked,
    input  logic [DATA_WIDTH*MASTERS-1:0]     mDatIPacked,
    input  logic [SEL_WIDTH*MASTERS-1:0]      mSelIPacked,
    output logic [MASTERS-1:0]                mAckO,
    output logic [MASTERS-1:0]                mErrO,
    output logic [DATA_WIDTH*MASTERS-1:0]     mDatOPacked,
    output logic                              sCycO,
    output logic                              sStbO,
    output logic                              sWeO,
    output logic [ADDRESS_WIDTH-1:0]          sAdrO,
    output logic [DATA_WIDTH-1:0]             sDatO,
    output logic [SEL_WIDTH-1:0]              sSelO,
    input  logic                              sAckI,
    input  logic                              sErrI,
    input  logic [DATA_WIDTH-1:0]             sDatI,
    output logic [GW-1:0]                     grant,
    output logic                              grantValid,
    output logic                              timeoutO
);

    arbState_t     state;
    arbState_t     stateNext;
    logic [GW-1:0] last;
    logic [GW-1:0] lastNext;
    logic [GW-1:0] grantNext;
    logic [GW-1:0] winner;
    logic          anyReq;
    logic          stalled;
    logic          expire;

    wb_rr_pick #(
        .MASTERS (MASTERS),
        .MODE    (MODE)
    ) uPick (
        .req    (mCycI),
        .last   (last),
        .winner (winner),
        .any    (anyReq)
    );

    assign grantValid  = (state == BUSY);
    assign stalled     = grantValid && mCycI[grant] && mStbI[grant] && !sAckI && !sErrI;
    assign mDatOPacked = {MASTERS{sDatI}};
    assign sAdrO       = mAdrIPacked[grant*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sDatO       = mDatIPacked[grant*DATA_WIDTH +: DATA_WIDTH];
    assign sSelO       = mSelIPacked[grant*SEL_WIDTH +: SEL_WIDTH];
    assign timeoutO    = expire;

    // Counts consecutive strobed cycles with no slave response; an ack in the
    // expiry cycle makes 'stalled' low, so the ack wins over the abort.
    generate
        if (TIMEOUT > 0) begin : gWatchdog
            localparam int            CW    = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] TOP   = CW'(TIMEOUT);
            logic [CW-1:0] count;

            always_ff @(posedge clk) begin
                if (rst || !stalled) begin
                    count <= '0;
                end else if (count != TOP) begin
                    count <= count + CW'(1);
                end
            end

            assign expire = stalled && (count == LIMIT);
        end else begin : gNoWatchdog
            assign expire = 1'b0;
        end
    endgenerate

    always_comb begin
        stateNext = state;
        grantNext = grant;
        lastNext  = last;
        sCycO     = 1'b0;
        sStbO     = 1'b0;
        sWeO      = 1'b0;
        mAckO     = '0;
        mErrO     = '0;
        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    grantNext = winner;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                sCycO        = mCycI[grant];
                sStbO        = mStbI[grant];
                sWeO         = mWeI[grant];
                mAckO[grant] = sAckI;
                mErrO[grant] = sErrI;
                if (!mCycI[grant]) begin
                    lastNext  = grant;
                    stateNext = IDLE;
                end else if (expire) begin
                    stateNext = ABORT;
                end
            end
            ABORT: begin
                // The slave is already disconnected; keep erroring until the owner gives up.
                mErrO[grant] = mCycI[grant];
                if (!mCycI[grant]) begin
                    lastNext  = grant;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= GW'(MASTERS - 1);
        end else begin
            state <= stateNext;
            grant <= grantNext;
            last  <= lastNext;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomised scoreboard bench for wb_rr_arbiter (3 masters, round-robin, short watchdog).
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

    localparam int M  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int TO = 6;
    localparam int GW = $clog2(M);

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    mCycI, mStbI, mWeI, mAckO, mErrO;
    logic [AW*M-1:0] mAdrIPacked;
    logic [DW*M-1:0] mDatIPacked, mDatOPacked;
    logic [SW*M-1:0] mSelIPacked;
    logic            sCycO, sStbO, sWeO, sAckI, sErrI, grantValid, timeoutO;
    logic [AW-1:0]   sAdrO;
    logic [DW-1:0]   sDatO, sDatI;
    logic [SW-1:0]   sSelO;
    logic [GW-1:0]   grant;

    logic [M-1:0]    pickReq;
    logic [GW-1:0]   pickLast, pickWin;
    logic            pickAny;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .MASTERS(M), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .MODE(MODE_RR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .mCycI(mCycI), .mStbI(mStbI), .mWeI(mWeI),
        .mAdrIPacked(mAdrIPacked), .mDatIPacked(mDatIPacked), .mSelIPacked(mSelIPacked),
        .mAckO(mAckO), .mErrO(mErrO), .mDatOPacked(mDatOPacked),
        .sCycO(sCycO), .sStbO(sStbO), .sWeO(sWeO),
        .sAdrO(sAdrO), .sDatO(sDatO), .sSelO(sSelO),
        .sAckI(sAckI), .sErrI(sErrI), .sDatI(sDatI),
        .grant(grant), .grantValid(grantValid), .timeoutO(timeoutO)
    );

    wb_rr_pick #(.MASTERS(M), .MODE(MODE_FIXED)) uFixPick (
        .req(pickReq), .last(pickLast), .winner(pickWin), .any(pickAny)
    );

    typedef struct {
        logic          gv;
        logic [GW-1:0] g;
        logic          sCyc, sStb, sWe;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic [M-1:0]  ack, err;
        logic          to;
        logic [DW-1:0] rdat;
    } exp_t;

    exp_t expQ[$];

    int nChecks = 0;
    int nPass   = 0;

    // Abstract model: who owns the port (-1 = nobody), whether it was aborted,
    // who owned it last, and how long the current stall has lasted.
    int own, lastOwner, stall, dead;
    bit aborted, stopNew, monOn;

    int            beats[M];
    int            cool[M];
    logic [AW-1:0] mAdr[M];
    logic [DW-1:0] mDat[M];
    logic [SW-1:0] mSel[M];
    logic          mWe[M];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic stepCycle(input bit doRst);
        exp_t         e;
        logic [M-1:0] cyc, stb, we;
        logic         ack, err, stalled, found;
        logic [GW-1:0] fixExp;
        int           r, c;

        for (int i = 0; i < M; i++) begin
            if (!stopNew && beats[i] == 0 && cool[i] == 0 && $urandom_range(0, 3) == 0) begin
                beats[i] = int'($urandom_range(1, 4));
                mAdr[i]  = AW'($urandom);
                mDat[i]  = DW'($urandom);
                mSel[i]  = SW'($urandom);
                mWe[i]   = 1'($urandom);
            end
            cyc[i] = (beats[i] > 0);
            stb[i] = cyc[i] && ($urandom_range(0, 7) != 0);
            we[i]  = mWe[i];
            mAdrIPacked[i*AW +: AW] = mAdr[i];
            mDatIPacked[i*DW +: DW] = mDat[i];
            mSelIPacked[i*SW +: SW] = mSel[i];
        end
        mCycI = cyc;
        mStbI = stb;
        mWeI  = we;

        ack = 1'b0;
        err = 1'b0;
        if (dead > 0) dead--;
        else if (!stopNew && $urandom_range(0, 79) == 0) dead = 10;
        if (!doRst && own >= 0 && !aborted && stb[own] && dead == 0) begin
            r   = int'($urandom_range(0, 19));
            ack = (r < 12) || (r == 19);
            err = (r == 18) || (r == 19);
        end
        sAckI = ack;
        sErrI = err;
        sDatI = DW'($urandom);
        rst   = doRst;

        e = '{default: '0};
        e.rdat  = sDatI;
        stalled = 1'b0;
        if (own >= 0) begin
            e.g = GW'(own);
            if (!aborted) begin
                e.gv       = 1'b1;
                e.sCyc     = cyc[own];
                e.sStb     = stb[own];
                e.sWe      = we[own];
                e.adr      = mAdr[own];
                e.dat      = mDat[own];
                e.sel      = mSel[own];
                e.ack[own] = ack;
                e.err[own] = err;
                stalled    = cyc[own] && stb[own] && !ack && !err;
                e.to       = stalled && (stall + 1 == TO);
            end else begin
                e.err[own] = cyc[own];
            end
        end
        if (e.gv || (|e.err)) expQ.push_back(e);

        for (int i = 0; i < M; i++) begin
            if (cool[i] > 0) cool[i]--;
            if ((e.ack[i] || e.err[i]) && beats[i] > 0) begin
                beats[i]--;
                if (beats[i] == 0) cool[i] = 1;
            end
        end

        if (doRst) begin
            own = -1; aborted = 0; lastOwner = M - 1; stall = 0;
            for (int i = 0; i < M; i++) begin
                beats[i] = 0;
                cool[i]  = 0;
            end
        end else if (own < 0) begin
            found = 1'b0;
            for (int k = 1; k <= M; k++) begin
                c = (lastOwner + k) % M;
                if (!found && cyc[c]) begin
                    own   = c;
                    found = 1'b1;
                end
            end
            stall = 0;
        end else if (!aborted) begin
            if (!cyc[own]) begin
                lastOwner = own; own = -1; stall = 0;
            end else if (e.to) begin
                aborted = 1; stall = 0;
            end else begin
                stall = stalled ? stall + 1 : 0;
            end
        end else if (!cyc[own]) begin
            lastOwner = own; own = -1; aborted = 0;
        end

        pickReq  = M'($urandom);
        pickLast = GW'($urandom_range(0, M - 1));
        #1;
        fixExp = '0;
        for (int i = M - 1; i >= 0; i--) if (pickReq[i]) fixExp = GW'(i);
        check("fixed-any", pickAny, |pickReq);
        if (|pickReq) check("fixed-winner", pickWin, fixExp);

        @(posedge clk);
        #1;
    endtask

    exp_t monExp;
    logic monPresent;

    always @(negedge clk) begin
        if (monOn) begin
            monPresent = grantValid | (|mErrO) | timeoutO | sCycO;
            if (monPresent) begin
                if (expQ.size() == 0) begin
                    check("output-present", monPresent, 1'b0);
                end else begin
                    monExp = expQ.pop_front();
                    check("grantValid", grantValid, monExp.gv);
                    if (monExp.gv) begin
                        check("grant", grant, monExp.g);
                        check("read-data", mDatOPacked[monExp.g*DW +: DW], monExp.rdat);
                    end
                    check("sCycO", sCycO, monExp.sCyc);
                    check("sStbO", sStbO, monExp.sStb);
                    check("sWeO", sWeO, monExp.sWe);
                    if (monExp.sCyc) begin
                        check("sAdrO", sAdrO, monExp.adr);
                        check("sDatO", sDatO, monExp.dat);
                        check("sSelO", sSelO, monExp.sel);
                    end
                    check("mAckO", mAckO, monExp.ack);
                    check("mErrO", mErrO, monExp.err);
                    check("timeoutO", timeoutO, monExp.to);
                end
            end else if (expQ.size() != 0) begin
                monExp = expQ.pop_front();
                check("output-present", monPresent, 1'b1);
            end else begin
                check("idle-ack", mAckO, '0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        mCycI = '0; mStbI = '0; mWeI = '0;
        mAdrIPacked = '0; mDatIPacked = '0; mSelIPacked = '0;
        sAckI = 1'b0; sErrI = 1'b0; sDatI = '0;
        pickReq = '0; pickLast = '0;
        own = -1; lastOwner = M - 1; stall = 0; dead = 0;
        aborted = 0; stopNew = 0; monOn = 0;
        for (int i = 0; i < M; i++) begin
            beats[i] = 0; cool[i] = 0;
            mAdr[i] = '0; mDat[i] = '0; mSel[i] = '0; mWe[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset-grantValid", grantValid, 1'b0);
        check("reset-grant", grant, '0);
        check("reset-sCycO", sCycO, 1'b0);
        check("reset-sStbO", sStbO, 1'b0);
        check("reset-mAckO", mAckO, '0);
        check("reset-mErrO", mErrO, '0);
        check("reset-timeoutO", timeoutO, 1'b0);
        monOn = 1'b1;
        @(posedge clk);
        #1;

        repeat (3000) stepCycle($urandom_range(0, 199) == 0);
        stopNew = 1'b1;
        repeat (150) stepCycle(1'b0);
        check("queue-drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
